sp_usb_fifo_bridge: RTL and testbench
=====================================

Name: sp_usb_fifo_bridge

Overview:
Parametrised bridge between an FT245-style synchronous USB FIFO chip and the on-chip byte stream interface.
- Replaces the single-byte buffering of the earlier USB bridge with independent TX and RX FIFOs of configurable depth.
- Bus timing (setup, strobe width, sample point, recovery) is configurable per board clock.
- Read/write arbitration is fair, and both FIFOs expose occupancy counts.
- Sits between the top-level USB pins and the host-stream kernels.

Parameters:
TX_DEPTH_LOG2, 4, log2 of TX FIFO depth (16 bytes); range 1..10
RX_DEPTH_LOG2, 4, log2 of RX FIFO depth (16 bytes); range 1..10
SETUP_CYCLES, 1, cycles data is driven with wr_n high before wr_n falls; >=1
STROBE_CYCLES, 3, cycles rd_n/wr_n held low; >=2
SAMPLE_CYCLE, 2, strobe cycle index (1-based) at whose end usb_data is captured; 1..STROBE_CYCLES
RECOVER_CYCLES, 3, idle cycles after each transfer before rxf/txe are re-evaluated; >=SYNC_STAGES+1
SYNC_STAGES, 2, synchroniser depth for rxf_n/txe_n; >=2

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
usb_data  inout  8  USB chip data bus
rxf_n  in  1  chip has a byte for us (active low, async)
txe_n  in  1  chip can accept a byte (active low, async)
rd_n  out  1  chip read strobe (active low)
wr_n  out  1  chip write strobe (active low)
din  in  8  byte to send to host
write  in  1  push din into TX FIFO
full  out  1  TX FIFO full
dout  out  8  head byte of RX FIFO (first-word fall-through)
read  in  1  pop RX FIFO
avail  out  1  RX FIFO non-empty
tx_count  out  TX_DEPTH_LOG2+1  TX FIFO occupancy
rx_count  out  RX_DEPTH_LOG2+1  RX FIFO occupancy

Behaviour:
Reset:
- Asserting rst immediately forces rd_n=1 and wr_n=1, tri-states usb_data, sends state to IDLE, and empties both FIFOs.
- After reset: full=0, avail=0, tx_count=0, rx_count=0. dout is don't-care while avail=0.
- Reset during a strobe aborts the strobe; the byte being transferred is lost.

Synchronisers:
- rxf = AND of all SYNC_STAGES synchroniser flops of ~rxf_n; txe is formed the same way from ~txe_n.
- Synchroniser flops are cleared to 0 by reset.

FIFOs:
- write while full: ignored and byte dropped; full stays 1.
- read while !avail: ignored.
- write and an internal TX pop in the same cycle: both take effect, count unchanged.
- Same rule for read plus an internal RX push.
- Pointers wrap modulo depth; counts saturate at 0 and depth by construction.
- full and avail reflect registered state; no combinational path from write/read.

State machine (one registered state; down-counter for multi-cycle states):
- IDLE
  - want_w = TX non-empty & txe.
  - want_r = rx_count + 0 < depth (space) & rxf.
  - If both are set, the direction opposite the last transfer wins (toggle bit; reset value favours write).
  - Go to WSETUP or RSTROBE accordingly; otherwise stay.
- WSETUP (SETUP_CYCLES): drive usb_data = TX head; wr_n=1.
- WSTROBE (STROBE_CYCLES): keep driving; wr_n=0.
- WHOLD (1 cycle): keep driving; wr_n=1. Pop TX FIFO on entry to WHOLD. Then go to RECOVER.
- RSTROBE (STROBE_CYCLES): rd_n=0; bus tri-stated.
  - Capture usb_data at the end of strobe cycle SAMPLE_CYCLE.
  - Push into the RX FIFO on the last strobe cycle.
  - Then go to RECOVER.
- RECOVER (RECOVER_CYCLES): rd_n=wr_n=1, bus tri-stated, then IDLE.
- rd_n, wr_n and the bus-drive enable are flops loaded from next_state, so they change on the same edge as state. No glitches.
- RX space is checked in IDLE only, and the FIFO cannot fill during a read because no other pusher exists. The read therefore never overflows.
- Bus drive enable and rd_n=0 are never active in the same cycle.

Latency (defaults, edge 0 = the write edge on an empty idle bridge with txe high):
- WSETUP at edge 1.
- wr_n low after edges 2, 3, 4; high at edge 5.
- tx_count decrements at edge 5.
- IDLE again after edge 9.

Test Plan:
1. Reset, txe_n=0, write 0xA5 -> usb_data=0xA5 driven from edge 1 to edge 6; wr_n low exactly 3 cycles (edges 2-4); tx_count 1->0 at edge 5.
2. rxf_n=0, chip model presents 0x3C one cycle after rd_n falls -> rd_n low 3 cycles; avail=1, dout=0x3C, rx_count=1; read pops and avail returns to 0.
3. rxf_n=0 and txe_n=0 continuously with TX preloaded with 0x01,0x02,0x03 -> transfers alternate W,R,W,R,W, then only reads continue.
4. Write 17 bytes with txe_n=1 -> full=1 after the 16th byte; 17th dropped; tx_count=16. Release txe_n -> 16 bytes leave in order 0..15.
5. rxf_n=0 with the reader stalled -> exactly 16 reads, then rd_n stays 1; after one read pulse a single further read occurs.
6. Assert rst mid-WSTROBE -> wr_n=1 and bus Z in the same cycle (asynchronous); counts=0; no transfers after release until new data is written.

Source files
------------

// File: rtl/sp_usb_fifo_bridge_if.sv
// Byte-stream side of the USB FIFO bridge: TX push, RX pop (first-word
// fall-through) and the occupancy counts of both FIFOs.
interface sp_usb_fifo_bridge_if #(
  parameter int TX_DEPTH_LOG2 = 4,
  parameter int RX_DEPTH_LOG2 = 4
);
  logic [7:0]             din;
  logic                   write;
  logic                   full;
  logic [7:0]             dout;
  logic                   read;
  logic                   avail;
  logic [TX_DEPTH_LOG2:0] tx_count;
  logic [RX_DEPTH_LOG2:0] rx_count;

  // Stream client: pushes TX bytes and pops RX bytes.
  modport master (output din, write, read,
                  input  full, dout, avail, tx_count, rx_count);
  // Bridge side.
  modport slave  (input  din, write, read,
                  output full, dout, avail, tx_count, rx_count);
endinterface

// File: rtl/sp_usb_fifo_bridge.sv
// Bridge between an FT245-style USB FIFO chip and the on-chip byte stream.
// Independent TX/RX FIFOs, configurable bus timing and fair read/write
// arbitration. The chip flags are synchronised before use.
module sp_usb_fifo_bridge #(
  parameter int TX_DEPTH_LOG2  = 4,
  parameter int RX_DEPTH_LOG2  = 4,
  parameter int SETUP_CYCLES   = 1,
  parameter int STROBE_CYCLES  = 3,
  parameter int SAMPLE_CYCLE   = 2,
  parameter int RECOVER_CYCLES = 3,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire  [7:0] usb_data,
  input  logic       rxf_n,
  input  logic       txe_n,
  output logic       rd_n,
  output logic       wr_n,
  sp_usb_fifo_bridge_if.slave sif
);
  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
  localparam logic [TX_DEPTH_LOG2:0] TX_FULL_CNT = {1'b1, {TX_DEPTH_LOG2{1'b0}}};
  localparam logic [RX_DEPTH_LOG2:0] RX_FULL_CNT = {1'b1, {RX_DEPTH_LOG2{1'b0}}};
  localparam logic [15:0] SETUP_LAST   = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] STROBE_LAST  = 16'(STROBE_CYCLES - 1);
  localparam logic [15:0] RECOVER_LAST = 16'(RECOVER_CYCLES - 1);
  // Counter value during the strobe cycle at whose end the bus is sampled.
  localparam logic [15:0] SAMPLE_AT    = 16'(STROBE_CYCLES - SAMPLE_CYCLE);

  typedef enum logic [2:0] {
    S_IDLE, S_WSETUP, S_WSTROBE, S_WHOLD, S_RSTROBE, S_RECOVER
  } state_t;

  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic last_wr_q, last_wr_d;             // 1: last transfer was a write
  logic [7:0] data_q, data_d;             // byte driven onto the bus
  logic [7:0] cap_q, cap_d;               // byte sampled from the bus
  logic rd_n_q, rd_n_d, wr_n_q, wr_n_d, drive_q, drive_d;
  logic [SYNC_STAGES-1:0] rxf_sync_q, rxf_sync_d, txe_sync_q, txe_sync_d;

  logic [7:0] tx_mem [TX_DEPTH];
  logic [7:0] rx_mem [RX_DEPTH];
  logic [TX_DEPTH_LOG2-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [RX_DEPTH_LOG2-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [TX_DEPTH_LOG2:0] tx_count_q, tx_count_d;
  logic [RX_DEPTH_LOG2:0] rx_count_q, rx_count_d;

  logic rxf, txe, tx_push, tx_pop, rx_push, rx_pop, want_w, want_r;
  logic [7:0] rx_push_data;

  assign rxf = &rxf_sync_q;
  assign txe = &txe_sync_q;

  // Synchroniser shift chains for the asynchronous chip flags.
  always_comb begin
    rxf_sync_d = {rxf_sync_q[SYNC_STAGES-2:0], ~rxf_n};
    txe_sync_d = {txe_sync_q[SYNC_STAGES-2:0], ~txe_n};
  end

  // FIFO pointer and occupancy bookkeeping; a push and pop together cancel.
  always_comb begin
    tx_push     = sif.write && (tx_count_q != TX_FULL_CNT);
    rx_pop      = sif.read && (rx_count_q != '0);
    tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + 1'b1 : tx_wr_ptr_q;
    tx_rd_ptr_d = tx_pop  ? tx_rd_ptr_q + 1'b1 : tx_rd_ptr_q;
    rx_wr_ptr_d = rx_push ? rx_wr_ptr_q + 1'b1 : rx_wr_ptr_q;
    rx_rd_ptr_d = rx_pop  ? rx_rd_ptr_q + 1'b1 : rx_rd_ptr_q;
    tx_count_d  = tx_count_q;
    rx_count_d  = rx_count_q;
    if (tx_push && !tx_pop) tx_count_d = tx_count_q + 1'b1;
    if (!tx_push && tx_pop) tx_count_d = tx_count_q - 1'b1;
    if (rx_push && !rx_pop) rx_count_d = rx_count_q + 1'b1;
    if (!rx_push && rx_pop) rx_count_d = rx_count_q - 1'b1;
  end

  // Bus sequencer: arbitration in IDLE, then timed write or read cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_wr_d    = last_wr_q;
    data_d       = data_q;
    cap_d        = cap_q;
    tx_pop       = 1'b0;
    rx_push      = 1'b0;
    rx_push_data = cap_q;
    want_w       = (tx_count_q != '0) && txe;
    want_r       = (rx_count_q < RX_FULL_CNT) && rxf;
    case (state_q)
      S_IDLE: begin
        if (want_w && (!want_r || !last_wr_q)) begin
          state_d   = S_WSETUP;
          cnt_d     = SETUP_LAST;
          data_d    = tx_mem[tx_rd_ptr_q];
          last_wr_d = 1'b1;
        end else if (want_r) begin
          state_d   = S_RSTROBE;
          cnt_d     = STROBE_LAST;
          last_wr_d = 1'b0;
        end
      end
      S_WSETUP: begin
        if (cnt_q == '0) begin
          state_d = S_WSTROBE;
          cnt_d   = STROBE_LAST;
        end else cnt_d = cnt_q - 1'b1;
      end
      S_WSTROBE: begin
        if (cnt_q == '0) begin
          state_d = S_WHOLD;
          tx_pop  = 1'b1;
        end else cnt_d = cnt_q - 1'b1;
      end
      S_WHOLD: begin
        state_d = S_RECOVER;
        cnt_d   = RECOVER_LAST;
      end
      S_RSTROBE: begin
        if (cnt_q == SAMPLE_AT) cap_d = usb_data;
        if (cnt_q == '0) begin
          rx_push      = 1'b1;
          rx_push_data = (cnt_q == SAMPLE_AT) ? usb_data : cap_q;
          state_d      = S_RECOVER;
          cnt_d        = RECOVER_LAST;
        end else cnt_d = cnt_q - 1'b1;
      end
      S_RECOVER: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else cnt_d = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    rd_n_d  = (state_d != S_RSTROBE);
    wr_n_d  = (state_d != S_WSTROBE);
    drive_d = (state_d == S_WSETUP) || (state_d == S_WSTROBE) || (state_d == S_WHOLD);
  end

  // Control and status registers; reset releases the bus immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_wr_q   <= 1'b0;
      data_q      <= '0;
      cap_q       <= '0;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      drive_q     <= 1'b0;
      rxf_sync_q  <= '0;
      txe_sync_q  <= '0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      rx_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_wr_q   <= last_wr_d;
      data_q      <= data_d;
      cap_q       <= cap_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      drive_q     <= drive_d;
      rxf_sync_q  <= rxf_sync_d;
      txe_sync_q  <= txe_sync_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      tx_count_q  <= tx_count_d;
      rx_count_q  <= rx_count_d;
    end
  end

  // FIFO storage writes (no reset on the data arrays).
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_q] <= sif.din;
    if (rx_push) rx_mem[rx_wr_ptr_q] <= rx_push_data;
  end

  assign usb_data     = drive_q ? data_q : 8'hzz;
  assign rd_n         = rd_n_q;
  assign wr_n         = wr_n_q;
  assign sif.full     = (tx_count_q == TX_FULL_CNT);
  assign sif.avail    = (rx_count_q != '0);
  assign sif.dout     = rx_mem[rx_rd_ptr_q];
  assign sif.tx_count = tx_count_q;
  assign sif.rx_count = rx_count_q;
endmodule

// File: tb/tb_sp_usb_fifo_bridge.sv
// Directed testbench for sp_usb_fifo_bridge with a simple FT245 chip model.
module tb_sp_usb_fifo_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxf_n = 1'b1;
  logic txe_n = 1'b1;
  logic rd_n, wr_n;
  wire  [7:0] usb_data;
  logic chip_drive = 1'b0;
  logic [7:0] chip_base = 8'h00;
  int rd_cnt = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] tx_log [$];
  logic xfer_log [$];

  sp_usb_fifo_bridge_if #(.TX_DEPTH_LOG2(4), .RX_DEPTH_LOG2(4)) sif ();

  sp_usb_fifo_bridge dut (
    .clk(clk), .rst(rst), .usb_data(usb_data), .rxf_n(rxf_n), .txe_n(txe_n),
    .rd_n(rd_n), .wr_n(wr_n), .sif(sif)
  );

  always #5 clk = ~clk;

  // Chip model: drives the RX byte one cycle after rd_n falls.
  always @(posedge clk) chip_drive <= !rd_n;
  assign usb_data = chip_drive ? 8'(chip_base + rd_cnt[7:0]) : 8'hzz;

  // Chip model: latches bytes on wr_n rising, counts completed reads.
  always @(posedge wr_n) if (!rst) tx_log.push_back(usb_data);
  always @(posedge rd_n) if (!rst) rd_cnt++;
  always @(negedge wr_n) if (!rst) xfer_log.push_back(1'b1);
  always @(negedge rd_n) if (!rst) xfer_log.push_back(1'b0);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else $display("ok   %s: %0h", tag, got);
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    sif.din = b;
    sif.write = 1'b1;
    @(negedge clk);
    sif.write = 1'b0;
  endtask

  task automatic pop_byte();
    @(negedge clk);
    sif.read = 1'b1;
    @(negedge clk);
    sif.read = 1'b0;
  endtask

  task automatic drain_rx();
    for (int g = 0; g < 40 && sif.avail; g++) pop_byte();
  endtask

  initial begin
    int rd0, guard, low;
    sif.din = 8'h00;
    sif.write = 1'b0;
    sif.read = 1'b0;

    // Reset state
    txe_n = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_val("rst_full", sif.full, 0);
    check_val("rst_avail", sif.avail, 0);
    check_val("rst_tx_count", sif.tx_count, 0);
    check_val("rst_rx_count", sif.rx_count, 0);
    check_val("rst_rd_wr", {rd_n, wr_n}, 2'b11);
    check_val("rst_bus_z", usb_data === 8'hzz, 1);

    // Test 1: write latency and strobe timing
    @(negedge clk);
    sif.din = 8'hA5;
    sif.write = 1'b1;
    @(posedge clk); #1;
    sif.write = 1'b0;
    check_val("t1_e0_tx_count", sif.tx_count, 1);
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk); #1;
      check_val($sformatf("t1_e%0d_wr_n", e), wr_n, (e >= 2 && e <= 4) ? 0 : 1);
      check_val($sformatf("t1_e%0d_rd_n", e), rd_n, 1);
      check_val($sformatf("t1_e%0d_tx_count", e), sif.tx_count, (e >= 5) ? 0 : 1);
      if (e <= 5) check_val($sformatf("t1_e%0d_bus", e), usb_data, 8'hA5);
      else        check_val("t1_e6_bus_z", usb_data === 8'hzz, 1);
    end
    repeat (6) @(negedge clk);
    check_val("t1_tx_byte", tx_log.size() == 1 && tx_log[0] == 8'hA5, 1);

    // Test 2: single read from chip
    txe_n = 1'b1;
    chip_base = 8'h3C - rd_cnt[7:0];
    rxf_n = 1'b0;
    guard = 0;
    while (rd_n && guard < 50) begin @(negedge clk); guard++; end
    check_val("t2_rd_seen", rd_n, 0);
    rxf_n = 1'b1;
    low = 0;
    while (!rd_n && low < 20) begin low++; @(negedge clk); end
    check_val("t2_rd_low_cycles", low, 3);
    repeat (5) @(negedge clk);
    check_val("t2_avail", sif.avail, 1);
    check_val("t2_dout", sif.dout, 8'h3C);
    check_val("t2_rx_count", sif.rx_count, 1);
    pop_byte();
    check_val("t2_avail_after_pop", sif.avail, 0);
    check_val("t2_rx_count_after_pop", sif.rx_count, 0);
    repeat (10) @(negedge clk);

    // Test 3: fair arbitration with both flags asserted
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    check_val("t3_preload", sif.tx_count, 3);
    tx_log.delete();
    xfer_log.delete();
    rxf_n = 1'b0;
    txe_n = 1'b0;
    repeat (80) @(negedge clk);
    rxf_n = 1'b1;
    txe_n = 1'b1;
    repeat (20) @(negedge clk);
    check_val("t3_xfers", xfer_log.size() >= 7, 1);
    if (xfer_log.size() >= 7)
      check_val("t3_order", {xfer_log[0], xfer_log[1], xfer_log[2], xfer_log[3],
                             xfer_log[4], xfer_log[5], xfer_log[6]}, 7'b1010100);
    check_val("t3_tx_bytes", tx_log.size() == 3 && tx_log[0] == 8'h01 &&
              tx_log[1] == 8'h02 && tx_log[2] == 8'h03, 1);
    check_val("t3_tx_empty", sif.tx_count, 0);
    drain_rx();
    check_val("t3_rx_drained", sif.rx_count, 0);

    // Test 4: TX overflow and in-order drain
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 15) check_val("t4_not_full_at_15", sif.full, 0);
      if (i == 16) check_val("t4_full_at_16", sif.full, 1);
      sif.din = 8'(i);
      sif.write = 1'b1;
    end
    @(negedge clk);
    sif.write = 1'b0;
    check_val("t4_tx_count", sif.tx_count, 16);
    check_val("t4_full_kept", sif.full, 1);
    tx_log.delete();
    txe_n = 1'b0;
    guard = 0;
    while (sif.tx_count != 0 && guard < 400) begin @(negedge clk); guard++; end
    repeat (2) @(negedge clk);
    txe_n = 1'b1;
    check_val("t4_drained", sif.tx_count, 0);
    check_val("t4_tx_log_size", tx_log.size(), 16);
    for (int i = 0; i < 16 && i < tx_log.size(); i++)
      check_val($sformatf("t4_byte%0d", i), tx_log[i], 8'(i));
    repeat (10) @(negedge clk);

    // Test 5: RX fills with reader stalled
    rd0 = rd_cnt;
    chip_base = 8'h40 - rd_cnt[7:0];
    rxf_n = 1'b0;
    repeat (250) @(negedge clk);
    check_val("t5_reads", rd_cnt - rd0, 16);
    check_val("t5_rx_count", sif.rx_count, 16);
    check_val("t5_rd_n_idle", rd_n, 1);
    check_val("t5_dout", sif.dout, 8'h40);
    pop_byte();
    repeat (40) @(negedge clk);
    check_val("t5_reads_after_pop", rd_cnt - rd0, 17);
    check_val("t5_rx_count_after", sif.rx_count, 16);
    check_val("t5_dout_after", sif.dout, 8'h41);
    rxf_n = 1'b1;
    repeat (10) @(negedge clk);
    drain_rx();
    check_val("t5_rx_drained", sif.rx_count, 0);

    // Test 6: asynchronous reset mid-strobe
    push_byte(8'h77);
    push_byte(8'h78);
    txe_n = 1'b0;
    guard = 0;
    while (wr_n && guard < 50) begin @(negedge clk); guard++; end
    check_val("t6_strobe_seen", wr_n, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("t6_wr_n_async", wr_n, 1);
    check_val("t6_bus_z_async", usb_data === 8'hzz, 1);
    check_val("t6_tx_count", sif.tx_count, 0);
    check_val("t6_rx_count", sif.rx_count, 0);
    check_val("t6_full_avail", {sif.full, sif.avail}, 2'b00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tx_log.delete();
    xfer_log.delete();
    repeat (40) @(negedge clk);
    check_val("t6_no_xfers", xfer_log.size(), 0);
    check_val("t6_wr_n_idle", wr_n, 1);
    push_byte(8'h99);
    repeat (20) @(negedge clk);
    check_val("t6_new_byte", tx_log.size() == 1 && tx_log[0] == 8'h99, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
